// File: rtl/integral_image_gen_if.sv
// Handshake bundle for integral_image_gen.
//   pix_*  : raster pixel stream into the generator (valid/ready, eot markers)
//   ii_*   : integral image output stream (valid/ready, eot markers)
//   sii_*  : squared integral image output stream (valid/ready, eot markers)
//   eot_err: sticky flag raised when upstream eot markers disagree with position
// Modports: slave = generator side, master = environment/producer-consumer side.
interface integral_image_gen_if #(
    parameter int W_PIX = 8,
    parameter int W_II  = 18,
    parameter int W_SII = 26
);
    logic             pix_valid;
    logic             pix_ready;
    logic [W_PIX-1:0] pix_data;
    logic [1:0]       pix_eot;
    logic             ii_valid;
    logic             ii_ready;
    logic [W_II-1:0]  ii_data;
    logic [1:0]       ii_eot;
    logic             sii_valid;
    logic             sii_ready;
    logic [W_SII-1:0] sii_data;
    logic [1:0]       sii_eot;
    logic             eot_err;

    modport slave (
        input  pix_valid, pix_data, pix_eot, ii_ready, sii_ready,
        output pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot, eot_err
    );

    modport master (
        output pix_valid, pix_data, pix_eot, ii_ready, sii_ready,
        input  pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot, eot_err
    );
endinterface

// File: rtl/integral_image_gen.sv
// integral_image_gen: turns one detection window of raster pixels into the
// integral image and the squared integral image, one word of each per pixel,
// one cycle after the pixel is accepted.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : integral_image_gen_if.slave (pixel input, ii/sii outputs, eot_err)
module integral_image_gen #(
    parameter int W_PIX         = 8,
    parameter int WINDOW_HEIGHT = 24,
    parameter int WINDOW_WIDTH  = 24,
    parameter int W_II          = 18,
    parameter int W_SII         = 26
) (
    input logic                  clk,
    input logic                  rst,
    integral_image_gen_if.slave  bus
);
    localparam int W_COL = (WINDOW_WIDTH  > 1) ? $clog2(WINDOW_WIDTH)  : 1;
    localparam int W_ROW = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;
    localparam logic [W_COL-1:0] COL_LAST = W_COL'(WINDOW_WIDTH - 1);
    localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(WINDOW_HEIGHT - 1);

    logic [W_COL-1:0] col;
    logic [W_ROW-1:0] row;
    logic [W_II-1:0]  row_sum;
    logic [W_SII-1:0] row_sq;
    logic [W_II-1:0]  lb_ii  [WINDOW_WIDTH];
    logic [W_SII-1:0] lb_sii [WINDOW_WIDTH];

    logic             ii_valid;
    logic [W_II-1:0]  ii_data;
    logic [1:0]       ii_eot;
    logic             sii_valid;
    logic [W_SII-1:0] sii_data;
    logic [1:0]       sii_eot;
    logic             eot_err;

    logic               pix_ready;
    logic               accept;
    logic               col_last;
    logic               row_last;
    logic [1:0]         eot_exp;
    logic [2*W_PIX-1:0] pix_sq;
    logic [W_II-1:0]    rs_next;
    logic [W_SII-1:0]   rq_next;
    logic [W_II-1:0]    ii_next;
    logic [W_SII-1:0]   sii_next;

    // A slot counts as free if it is empty or is handing off its word this
    // cycle; both slots must be free since they are loaded together.
    assign pix_ready = (~ii_valid | bus.ii_ready) & (~sii_valid | bus.sii_ready);
    assign accept    = bus.pix_valid & pix_ready;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign eot_exp  = {col_last & row_last, col_last};

    always_comb begin
        pix_sq   = {{W_PIX{1'b0}}, bus.pix_data} * {{W_PIX{1'b0}}, bus.pix_data};
        rs_next  = ((col == '0) ? '0 : row_sum) + W_II'(bus.pix_data);
        rq_next  = ((col == '0) ? '0 : row_sq) + W_SII'(pix_sq);
        // Row 0 ignores the line buffers, so stale data from a previous frame
        // never needs clearing.
        ii_next  = rs_next + ((row == '0) ? '0 : lb_ii[col]);
        sii_next = rq_next + ((row == '0) ? '0 : lb_sii[col]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            row_sum   <= '0;
            row_sq    <= '0;
            ii_valid  <= 1'b0;
            ii_data   <= '0;
            ii_eot    <= '0;
            sii_valid <= 1'b0;
            sii_data  <= '0;
            sii_eot   <= '0;
            eot_err   <= 1'b0;
            for (int i = 0; i < WINDOW_WIDTH; i++) begin
                lb_ii[i]  <= '0;
                lb_sii[i] <= '0;
            end
        end else begin
            if (accept) begin
                row_sum     <= rs_next;
                row_sq      <= rq_next;
                lb_ii[col]  <= ii_next;
                lb_sii[col] <= sii_next;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Counters stay authoritative; a bad marker is only flagged.
                if (bus.pix_eot != eot_exp) begin
                    eot_err <= 1'b1;
                end
            end

            if (accept) begin
                ii_valid <= 1'b1;
                ii_data  <= ii_next;
                ii_eot   <= eot_exp;
            end else if (bus.ii_ready) begin
                ii_valid <= 1'b0;
            end

            if (accept) begin
                sii_valid <= 1'b1;
                sii_data  <= sii_next;
                sii_eot   <= eot_exp;
            end else if (bus.sii_ready) begin
                sii_valid <= 1'b0;
            end
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.ii_valid  = ii_valid;
    assign bus.ii_data   = ii_data;
    assign bus.ii_eot    = ii_eot;
    assign bus.sii_valid = sii_valid;
    assign bus.sii_data  = sii_data;
    assign bus.sii_eot   = sii_eot;
    assign bus.eot_err   = eot_err;
endmodule

// File: tb/tb_integral_image_gen.sv
module tb_integral_image_gen;
    localparam int W_PIX = 8;
    localparam int WH    = 24;
    localparam int WW    = 24;
    localparam int W_II  = 18;
    localparam int W_SII = 26;
    localparam int NPIX  = WW * WH;

    logic clk;
    logic rst;

    integral_image_gen_if #(.W_PIX(W_PIX), .W_II(W_II), .W_SII(W_SII)) bus ();

    integral_image_gen #(
        .W_PIX(W_PIX), .WINDOW_HEIGHT(WH), .WINDOW_WIDTH(WW), .W_II(W_II), .W_SII(W_SII)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pixels of the current frame, position index.
    int               m_pix [NPIX];
    int               m_idx = 0;
    bit               exp_err = 0;
    logic [W_II+1:0]  ii_q[$];
    logic [W_SII+1:0] sii_q[$];
    logic [W_II+1:0]  ii_log[$];
    logic [W_SII+1:0] sii_log[$];

    int rdy_mode = 0;   // 0: both ready, 1: random, 2: sii stalled
    int drv_cycles = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Integral computed directly as a rectangle sum over the stored frame.
    task automatic model_accept(input int p, input logic [1:0] e);
        int     x;
        int     y;
        longint s;
        longint q;
        logic [1:0] eo;
        x = m_idx % WW;
        y = m_idx / WW;
        m_pix[m_idx] = p;
        s = 0;
        q = 0;
        for (int yy = 0; yy <= y; yy++)
            for (int xx = 0; xx <= x; xx++) begin
                s += m_pix[yy*WW + xx];
                q += m_pix[yy*WW + xx] * m_pix[yy*WW + xx];
            end
        eo = {(x == WW-1) && (y == WH-1), (x == WW-1)};
        if (e != eo) exp_err = 1;
        ii_q.push_back({eo, W_II'(s)});
        sii_q.push_back({eo, W_SII'(q)});
        m_idx = (m_idx + 1) % NPIX;
    endtask

    // Ready generator: the only process driving the consumer readies.
    initial begin
        bus.ii_ready  = 1'b1;
        bus.sii_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.ii_ready  = ($urandom_range(0, 3) != 0);
                    bus.sii_ready = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    bus.ii_ready  = 1'b1;
                    bus.sii_ready = 1'b0;
                end
                default: begin
                    bus.ii_ready  = 1'b1;
                    bus.sii_ready = 1'b1;
                end
            endcase
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_valid && bus.pix_ready)
                model_accept(int'(bus.pix_data), bus.pix_eot);
            if (bus.ii_valid && bus.ii_ready) begin
                if (ii_q.size() == 0) begin
                    check("ii_unexpected_word", longint'(bus.ii_data), -1);
                end else begin
                    check("ii_word", longint'({bus.ii_eot, bus.ii_data}), longint'(ii_q[0]));
                    void'(ii_q.pop_front());
                    ii_log.push_back({bus.ii_eot, bus.ii_data});
                end
            end
            if (bus.sii_valid && bus.sii_ready) begin
                if (sii_q.size() == 0) begin
                    check("sii_unexpected_word", longint'(bus.sii_data), -1);
                end else begin
                    check("sii_word", longint'({bus.sii_eot, bus.sii_data}), longint'(sii_q[0]));
                    void'(sii_q.pop_front());
                    sii_log.push_back({bus.sii_eot, bus.sii_data});
                end
            end
        end
    end

    // mode: 0 ones, 1 all-255, 2 twos, 3 ramp, 4 random. bad_idx injects a wrong eot.
    task automatic send_pix(input int n, input int mode, input bit gaps, input int bad_idx);
        int  k;
        int  x;
        int  y;
        int  t;
        bit  acc;
        drv_cycles = 0;
        for (int i = 0; i < n; i++) begin
            k = i % NPIX;
            x = k % WW;
            y = k / WW;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.pix_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.pix_valid = 1'b1;
            case (mode)
                0: bus.pix_data = 8'd1;
                1: bus.pix_data = 8'd255;
                2: bus.pix_data = 8'd2;
                3: bus.pix_data = 8'((x + 24 * y) % 256);
                default: bus.pix_data = 8'($urandom_range(0, 255));
            endcase
            bus.pix_eot = {(x == WW-1) && (y == WH-1), (x == WW-1)};
            if (k == bad_idx) bus.pix_eot = 2'b01;
            t = 0;
            forever begin
                @(negedge clk);
                acc = bus.pix_ready;
                @(posedge clk);
                #1;
                drv_cycles++;
                if (acc) break;
                t++;
                if (t > 2000) begin
                    check("pix_accept_timeout", t, 0);
                    break;
                end
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((ii_q.size() != 0 || sii_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_pending", ii_q.size() + sii_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ii_q.delete();
        sii_q.delete();
        ii_log.delete();
        sii_log.delete();
        m_idx = 0;
        exp_err = 0;
        #1;
        check("rst_ii_valid", bus.ii_valid, 0);
        check("rst_sii_valid", bus.sii_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hs;
        int t;
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_eot   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ii_valid", bus.ii_valid, 0);
        check("reset_sii_valid", bus.sii_valid, 0);
        check("reset_ii_data", bus.ii_data, 0);
        check("reset_sii_data", bus.sii_data, 0);
        check("reset_ii_eot", bus.ii_eot, 0);
        check("reset_sii_eot", bus.sii_eot, 0);
        check("reset_eot_err", bus.eot_err, 0);
        check("reset_pix_ready", bus.pix_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-ones frame at full rate.
        ii_log.delete(); sii_log.delete();
        send_pix(NPIX, 0, 0, -1);
        check("ones_full_rate_cycles", drv_cycles, NPIX);
        drain();
        check("ones_ii_count", ii_log.size(), NPIX);
        if (ii_log.size() == NPIX && sii_log.size() == NPIX) begin
            check("ones_ii_row0_end", longint'(ii_log[23]), longint'({2'b01, 18'd24}));
            check("ones_ii_last", longint'(ii_log[NPIX-1]), longint'({2'b11, 18'd576}));
            check("ones_sii_last", longint'(sii_log[NPIX-1]), longint'({2'b11, 26'd576}));
        end

        // All-255 frame: largest values.
        ii_log.delete(); sii_log.delete();
        send_pix(NPIX, 1, 0, -1);
        drain();
        check("max_ii_count", ii_log.size(), NPIX);
        if (ii_log.size() == NPIX && sii_log.size() == NPIX) begin
            check("max_ii_last", longint'(ii_log[NPIX-1][W_II-1:0]), 146880);
            check("max_sii_last", longint'(sii_log[NPIX-1][W_SII-1:0]), 37454400);
        end

        // Ramp and random frames with valid gaps and random readies.
        rdy_mode = 1;
        send_pix(NPIX, 3, 1, -1);
        send_pix(NPIX, 4, 1, -1);
        drain();
        rdy_mode = 0;
        check("ramp_eot_err", bus.eot_err, 0);

        // Back-pressure on sii only.
        fork
            send_pix(NPIX, 4, 0, -1);
            begin
                repeat (60) @(posedge clk);
                #1;
                rdy_mode = 2;
                t = 0;
                @(negedge clk);
                while (bus.sii_ready && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                check("bp_sii_ready_low", bus.sii_ready, 0);
                hs = 0;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    if (bus.ii_valid && bus.ii_ready) hs++;
                    check("bp_pix_ready", bus.pix_ready, 0);
                    check("bp_sii_valid", bus.sii_valid, 1);
                    if (sii_q.size() != 0)
                        check("bp_sii_data_held", longint'(bus.sii_data), longint'(sii_q[0][W_SII-1:0]));
                end
                check("bp_ii_handshakes", hs, 1);
                rdy_mode = 0;
            end
        join
        drain();

        // Back-to-back frames: ones then twos.
        ii_log.delete(); sii_log.delete();
        send_pix(NPIX, 0, 0, -1);
        send_pix(NPIX, 2, 0, -1);
        drain();
        check("b2b_ii_count", ii_log.size(), 2 * NPIX);
        if (ii_log.size() == 2 * NPIX) begin
            check("b2b_f2_first", longint'(ii_log[NPIX][W_II-1:0]), 2);
            check("b2b_f2_last", longint'(ii_log[2*NPIX-1][W_II-1:0]), 1152);
        end

        // Reset after 100 pixels, then a clean frame.
        send_pix(100, 0, 0, -1);
        do_reset();
        send_pix(NPIX, 0, 0, -1);
        drain();
        check("postrst_ii_count", ii_log.size(), NPIX);
        if (ii_log.size() == NPIX)
            check("postrst_ii_last", longint'(ii_log[NPIX-1]), longint'({2'b11, 18'd576}));

        // Wrong eot marker at column 10; data unaffected, flag sticky.
        rdy_mode = 1;
        send_pix(NPIX, 4, 1, 10);
        drain();
        rdy_mode = 0;
        check("eot_err_model", exp_err, 1);
        check("eot_err_set", bus.eot_err, 1);
        send_pix(NPIX, 0, 0, -1);
        drain();
        check("eot_err_sticky", bus.eot_err, 1);
        do_reset();
        @(negedge clk);
        check("eot_err_cleared", bus.eot_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
